matriz_max7219_ctrl: RTL

Serial loader that drives the MAX7219-based 8x8 LED matrix from the eight painted row buses (rows 7..0, 8 bits each) produced by the matrix painting stage. After reset it sends a fixed configuration sequence. On each frame request it snapshots the eight rows and shifts them out as eight 16-bit register writes. It is the only block that touches the matrix driver pins.

---
 rtl/matriz_max7219_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/matriz_max7219_ctrl.sv
// rtl/matriz_max7219_ctrl.sv - MAX7219 8x8 matrix serial loader (init sequence + frame refresh)
//
// Purpose: after reset, shifts the five MAX7219 configuration words out. On each frame
// request it snapshots the eight painted rows and sends them as digit registers 1..8.
// Each 16-bit word goes out MSB first on SCLK/DIN and is latched by a rising LOAD.
//
// Ports:
//   MATRIZ_CTRL_CLOCK            system clock, rising edge
//   MATRIZ_CTRL_RESET            synchronous active-low reset
//   MATRIZ_CTRL_ROW_7_IN..ROW_0  painted row data; row k goes to digit register k+1
//   MATRIZ_CTRL_FRAME_REQ        frame request pulse
//   MATRIZ_CTRL_SCLK_OUT         serial clock to driver
//   MATRIZ_CTRL_DIN_OUT          serial data, MSB first
//   MATRIZ_CTRL_LOAD_OUT         driver LOAD/CS, low while shifting
//   MATRIZ_CTRL_BUSY_OUT         high while an init or frame sequence runs
//   MATRIZ_CTRL_INIT_DONE_OUT    sticky, high once init has completed
//   MATRIZ_CTRL_FRAME_DONE_OUT   one-cycle pulse at the end of each frame

module matriz_max7219_ctrl #(
    parameter int         DATAWIDTH_BUS = 8,
    parameter int         CLK_DIV       = 4,
    parameter logic [3:0] INTENSITY     = 4'h8
) (
    input  logic                     MATRIZ_CTRL_CLOCK,
    input  logic                     MATRIZ_CTRL_RESET,
    input  logic [DATAWIDTH_BUS-1:0] MATRIZ_CTRL_ROW_7_IN,
    input  logic [DATAWIDTH_BUS-1:0] MATRIZ_CTRL_ROW_6_IN,
    input  logic [DATAWIDTH_BUS-1:0] MATRIZ_CTRL_ROW_5_IN,
    input  logic [DATAWIDTH_BUS-1:0] MATRIZ_CTRL_ROW_4_IN,
    input  logic [DATAWIDTH_BUS-1:0] MATRIZ_CTRL_ROW_3_IN,
    input  logic [DATAWIDTH_BUS-1:0] MATRIZ_CTRL_ROW_2_IN,
    input  logic [DATAWIDTH_BUS-1:0] MATRIZ_CTRL_ROW_1_IN,
    input  logic [DATAWIDTH_BUS-1:0] MATRIZ_CTRL_ROW_0_IN,
    input  logic                     MATRIZ_CTRL_FRAME_REQ,
    output logic                     MATRIZ_CTRL_SCLK_OUT,
    output logic                     MATRIZ_CTRL_DIN_OUT,
    output logic                     MATRIZ_CTRL_LOAD_OUT,
    output logic                     MATRIZ_CTRL_BUSY_OUT,
    output logic                     MATRIZ_CTRL_INIT_DONE_OUT,
    output logic                     MATRIZ_CTRL_FRAME_DONE_OUT
);

    // Phase counter must reach 2*CLK_DIV-1 for the LOAD-high gap.
    localparam int             CW         = $clog2(2 * CLK_DIV) + 1;
    localparam logic [CW-1:0]  PHASE_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  GAP_LAST   = CW'(2 * CLK_DIV - 1);
    localparam logic [15:0]    INIT_WORD0 = 16'h0C01;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_GAP,
        ST_WAIT
    } state_t;

    typedef logic [7:0][DATAWIDTH_BUS-1:0] rows_t;

    state_t          r_state;
    logic            r_mode_frame;
    logic [2:0]      r_word_idx;
    logic [3:0]      r_bit_idx;
    logic [CW-1:0]   r_cnt;
    rows_t           r_snap;
    logic            r_pending;
    logic            r_sclk;
    logic            r_din;
    logic            r_load;
    logic            r_busy;
    logic            r_init_done;
    logic            r_frame_done;

    rows_t           w_rows;
    logic [15:0]     w_cur_word;
    logic [15:0]     w_next_word;
    logic [15:0]     w_frame0_word;
    logic [2:0]      w_last_idx;
    logic [3:0]      w_bit_dn;

    function automatic logic [15:0] word_sel(input logic mode_frame, input logic [2:0] idx,
                                             input rows_t rows);
        logic [15:0] w;
        w = 16'h0000;
        if (mode_frame) begin
            w = {4'h0, {1'b0, idx} + 4'd1, 8'(rows[idx])};
        end else begin
            case (idx)
                3'd0:    w = INIT_WORD0;
                3'd1:    w = 16'h0900;
                3'd2:    w = {8'h0A, 4'h0, INTENSITY};
                3'd3:    w = 16'h0B07;
                default: w = 16'h0F00;
            endcase
        end
        return w;
    endfunction

    assign w_rows = {MATRIZ_CTRL_ROW_7_IN, MATRIZ_CTRL_ROW_6_IN, MATRIZ_CTRL_ROW_5_IN,
                     MATRIZ_CTRL_ROW_4_IN, MATRIZ_CTRL_ROW_3_IN, MATRIZ_CTRL_ROW_2_IN,
                     MATRIZ_CTRL_ROW_1_IN, MATRIZ_CTRL_ROW_0_IN};

    assign w_cur_word    = word_sel(r_mode_frame, r_word_idx, r_snap);
    assign w_next_word   = word_sel(r_mode_frame, r_word_idx + 3'd1, r_snap);
    // The snapshot is written on the same edge the first frame word starts,
    // so its MSB has to come straight from the row inputs.
    assign w_frame0_word = word_sel(1'b1, 3'd0, w_rows);
    assign w_last_idx    = r_mode_frame ? 3'd7 : 3'd4;
    assign w_bit_dn      = r_bit_idx - 4'd1;

    always_ff @(posedge MATRIZ_CTRL_CLOCK) begin
        if (!MATRIZ_CTRL_RESET) begin
            r_state      <= ST_RESET;
            r_mode_frame <= 1'b0;
            r_word_idx   <= 3'd0;
            r_bit_idx    <= 4'd15;
            r_cnt        <= '0;
            r_snap       <= '0;
            r_pending    <= 1'b0;
            r_sclk       <= 1'b0;
            r_din        <= 1'b0;
            r_load       <= 1'b1;
            r_busy       <= 1'b0;
            r_init_done  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            // Requests outside WAIT collapse into one pending frame.
            if (MATRIZ_CTRL_FRAME_REQ && (r_state != ST_WAIT)) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                ST_RESET: begin
                    r_state      <= ST_SHIFT_LO;
                    r_mode_frame <= 1'b0;
                    r_word_idx   <= 3'd0;
                    r_bit_idx    <= 4'd15;
                    r_cnt        <= '0;
                    r_sclk       <= 1'b0;
                    r_load       <= 1'b0;
                    r_busy       <= 1'b1;
                    r_din        <= INIT_WORD0[15];
                end

                ST_SHIFT_LO: begin
                    if (r_cnt == PHASE_LAST) begin
                        r_state <= ST_SHIFT_HI;
                        r_sclk  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_SHIFT_HI: begin
                    if (r_cnt == PHASE_LAST) begin
                        r_cnt  <= '0;
                        r_sclk <= 1'b0;
                        if (r_bit_idx == 4'd0) begin
                            r_state <= ST_GAP;
                            r_load  <= 1'b1;
                        end else begin
                            r_state   <= ST_SHIFT_LO;
                            r_bit_idx <= w_bit_dn;
                            r_din     <= w_cur_word[w_bit_dn];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt <= '0;
                        if (r_word_idx == w_last_idx) begin
                            r_state <= ST_WAIT;
                            r_busy  <= 1'b0;
                            if (r_mode_frame) begin
                                r_frame_done <= 1'b1;
                            end else begin
                                r_init_done <= 1'b1;
                            end
                        end else begin
                            r_state    <= ST_SHIFT_LO;
                            r_word_idx <= r_word_idx + 3'd1;
                            r_bit_idx  <= 4'd15;
                            r_load     <= 1'b0;
                            r_din      <= w_next_word[15];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (MATRIZ_CTRL_FRAME_REQ || r_pending) begin
                        r_state      <= ST_SHIFT_LO;
                        r_mode_frame <= 1'b1;
                        r_word_idx   <= 3'd0;
                        r_bit_idx    <= 4'd15;
                        r_cnt        <= '0;
                        r_snap       <= w_rows;
                        r_pending    <= 1'b0;
                        r_load       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_din        <= w_frame0_word[15];
                    end
                end

                default: begin
                    r_state <= ST_RESET;
                end
            endcase
        end
    end

    assign MATRIZ_CTRL_SCLK_OUT       = r_sclk;
    assign MATRIZ_CTRL_DIN_OUT        = r_din;
    assign MATRIZ_CTRL_LOAD_OUT       = r_load;
    assign MATRIZ_CTRL_BUSY_OUT       = r_busy;
    assign MATRIZ_CTRL_INIT_DONE_OUT  = r_init_done;
    assign MATRIZ_CTRL_FRAME_DONE_OUT = r_frame_done;

endmodule
